// File: rtl/collector_pkg.sv
// rtl/collector_pkg.sv - shared types and widths for the systolic output collector
package collector_pkg;

  localparam int M_ROWS        = 5;
  localparam int DEPTH_ENTRIES = 8;
  localparam int IDX_W         = $clog2(M_ROWS);
  localparam int PTR_W         = $clog2(DEPTH_ENTRIES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/collector_col_fifo.sv
// rtl/collector_col_fifo.sv - per-column deskew FIFO with flush and head read
module collector_col_fifo
  import collector_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = DEPTH_ENTRIES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy bookkeeping; flush discards everything queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; when full with a concurrent pop the write lands on the slot just read
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/systolic_output_collector.sv
// rtl/systolic_output_collector.sv - deskews K systolic columns into aligned result rows
module systolic_output_collector
  import collector_pkg::*;
#(
  parameter int M          = M_ROWS,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = DEPTH_ENTRIES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_WIDTH*K-1:0] y_in,
  input  logic [K-1:0]            y_valid,
  output logic [DATA_WIDTH*K-1:0] out_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  state_t                  r_state;
  logic [IDX_W-1:0]        r_cnt;
  logic                    r_err;

  logic [K-1:0]            w_full;
  logic [K-1:0]            w_empty;
  logic [K-1:0]            w_push;
  logic [DATA_WIDTH*K-1:0] w_head;
  logic                    w_in_run;
  logic                    w_flush;
  logic                    w_pop;
  logic                    w_last;
  logic                    w_err_new;

  assign w_in_run = (r_state == RUN);
  assign w_flush  = (r_state == FIN);
  assign w_push   = y_valid & {K{w_in_run}};

  for (genvar g = 0; g < K; g++) begin : g_col
    collector_col_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[g]),
      .i_data  (y_in[DATA_WIDTH*g +: DATA_WIDTH]),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_head  (w_head[DATA_WIDTH*g +: DATA_WIDTH])
    );
  end

  // A row is released only once every column holds its element
  assign out_valid = w_in_run && (w_empty == '0);
  assign out_row   = out_valid ? w_head : '0;
  assign w_pop     = out_valid && out_ready;
  assign w_last    = (r_cnt == IDX_W'(M-1));
  assign out_idx   = r_cnt;
  assign out_last  = w_last;
  assign busy      = (r_state == RUN);
  assign done      = (r_state == FIN);
  assign err       = r_err;

  // Protocol violations seen this cycle: stray pushes, overflow, restart, leftovers at job end
  assign w_err_new = ((|y_valid) && !w_in_run)
                  || ((|(y_valid & w_full)) && w_in_run && !w_pop)
                  || (start && (r_state != IDLE))
                  || (w_flush && (w_empty != '1));

  // Job sequencing and row counter, which wraps on the last accepted row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          if (w_pop) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= FIN;
            end else begin
              r_cnt <= r_cnt + IDX_W'(1);
            end
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky error; a fresh start clears history but still records same-cycle faults
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (start && (r_state == IDLE)) begin
      r_err <= w_err_new;
    end else begin
      r_err <= r_err | w_err_new;
    end
  end

endmodule

// File: tb/tb_systolic_output_collector.sv
// tb/tb_systolic_output_collector.sv - scoreboard bench for the systolic output collector
module tb_systolic_output_collector;

  localparam int M  = 5;
  localparam int K  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [DW*K-1:0] y_in;
  logic [K-1:0]    y_valid;
  logic [DW*K-1:0] out_row;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_idx;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            err;

  systolic_output_collector #(.M(M), .K(K), .DATA_WIDTH(DW), .DEPTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .y_in      (y_in),
    .y_valid   (y_valid),
    .out_row   (out_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW*K-1:0] row;
    logic [2:0]      idx;
    logic            last;
  } exp_t;

  exp_t            q[$];
  int              checks = 0;
  int              failures = 0;
  int              pops = 0;
  int              n_pushed = 0;
  logic            exp_done = 1'b0;
  logic            held_v = 1'b0;
  logic [DW*K-1:0] held_row;
  logic            saw_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW*K-1:0] row_of(input int m);
    logic [DW*K-1:0] r;
    for (int k = 0; k < K; k++) r[DW*k +: DW] = 8'(16*m + k);
    return r;
  endfunction

  task automatic push_exp(input logic [DW*K-1:0] r);
    exp_t e;
    e.row  = r;
    e.idx  = 3'(n_pushed % M);
    e.last = ((n_pushed % M) == M-1);
    q.push_back(e);
    n_pushed++;
  endtask

  task automatic clear_tb();
    q.delete();
    exp_done = 1'b0;
    held_v   = 1'b0;
    n_pushed = 0;
    pops     = 0;
    saw_done = 1'b0;
  endtask

  // One clock: sample outputs on the falling edge, score any accepted row, advance
  task automatic tick();
    logic nd;
    nd = 1'b0;
    @(negedge clk);
    chk("done", done, exp_done);
    if (done) saw_done = 1'b1;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("out_valid_without_expected_row", out_valid, 0);
      end else begin
        chk("out_row", out_row, q[0].row);
        chk("out_idx", out_idx, q[0].idx);
        chk("out_last", out_last, q[0].last);
        if (held_v && !out_ready) chk("held_row", out_row, held_row);
        if (out_ready) begin
          nd = out_last;
          void'(q.pop_front());
          pops++;
          held_v = 1'b0;
        end else begin
          held_v   = 1'b1;
          held_row = out_row;
        end
      end
    end else begin
      held_v = 1'b0;
    end
    exp_done = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
  endtask

  task automatic start_job();
    clear_tb();
    y_valid = '0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chk("err_after_start", err, 0);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic drain(input string tag);
    y_valid   = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && !saw_done; c++) tick();
    chk({tag, "_done_seen"}, saw_done, 1);
  endtask

  task automatic run_job(input int stall_until, input int abort_rows);
    int m;
    start_job();
    for (int c = 0; c < 60; c++) begin
      y_valid = '0;
      y_in    = '0;
      for (int k = 0; k < K; k++) begin
        m = c - k;
        if (m >= 0 && m < M) begin
          y_valid[k]      = 1'b1;
          y_in[DW*k +: DW] = 8'(16*m + k);
          if (k == 0) push_exp(row_of(m));
        end
      end
      out_ready = (c >= stall_until);
      tick();
      if (abort_rows > 0 && pops == abort_rows) begin
        y_valid = '0;
        rst_n   = 1'b0;
        #1;
        check_reset_outputs();
        clear_tb();
        tick();
        rst_n = 1'b1;
        break;
      end
      if (saw_done) break;
    end
    y_valid = '0;
    if (abort_rows == 0) begin
      chk("job_done_seen", saw_done, 1);
      chk("job_err", err, 0);
      chk("job_rows_left", q.size(), 0);
      chk("job_busy_end", busy, 0);
    end
  endtask

  initial begin
    logic [DW*K-1:0] r;
    rst_n     = 1'b0;
    start     = 1'b0;
    y_in      = '0;
    y_valid   = '0;
    out_ready = 1'b0;
    #12;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // skewed stream, consumer always ready
    run_job(0, 0);

    // same stream with the consumer stalled for the first ten cycles
    run_job(10, 0);

    // stray push while idle
    y_valid = 4'b0001;
    y_in    = 32'h0000_0055;
    tick();
    y_valid = '0;
    chk("idle_push_err", err, 1);
    chk("idle_push_out_valid", out_valid, 0);

    // start clears the error, then reset lands after row 2 is accepted
    run_job(0, 3);

    // a clean job after the mid-job reset
    run_job(0, 0);

    // fill every column, then push and pop together while full
    start_job();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      y_valid = 4'hF;
      y_in    = row_of(i);
      push_exp(row_of(i));
      tick();
    end
    chk("col3_full_count", u_dut.g_col[3].u_fifo.r_count, 8);
    y_valid   = 4'hF;
    y_in      = row_of(8);
    push_exp(row_of(8));
    out_ready = 1'b1;
    tick();
    chk("pushpop_err", err, 0);
    chk("pushpop_col3_count", u_dut.g_col[3].u_fifo.r_count, 8);
    drain("pushpop");
    clear_tb();

    // overflow column 0 with nine entries while stalled
    start_job();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      y_valid = 4'b0001;
      y_in    = {24'h0, 8'(8'hA0 + i)};
      tick();
      if (i == 7) chk("ovf_err_before", err, 0);
    end
    chk("ovf_err_after", err, 1);
    chk("ovf_col0_count", u_dut.g_col[0].u_fifo.r_count, 8);
    out_ready = 1'b1;
    for (int m = 0; m < M; m++) begin
      r        = row_of(m);
      r[7:0]   = 8'(8'hA0 + m);
      push_exp(r);
      y_valid  = 4'b1110;
      y_in     = row_of(m);
      y_in[7:0] = 8'h00;
      tick();
    end
    drain("ovf");
    chk("ovf_rows_left", q.size(), 0);
    clear_tb();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so a stuck design still ends the run
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/systolic_output_collector.md
Name: systolic_output_collector

Overview:
- Drain-side counterpart to the input feed of systolic_array: receives the K skewed column outputs of Y, deskews them, and emits one aligned result row per handshake.
- Column k delivers row m one cycle after column k-1 delivers it. The block buffers per column and releases a row only when every column holds that row's element.
- Sits between systolic_array.Y and the result consumer (writeback/memory path). It counts M rows per matrix and flags protocol errors.

Parameters:
- M, 5, rows per result matrix (rows per job)
- K, 4, number of array columns (elements per output row)
- DATA_WIDTH, 8, bits per element
- DEPTH, 8, entries per column FIFO; must be >= K and a power of 2

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a job of M rows
- y_in  input  DATA_WIDTH*K  array outputs; column k at bits [DATA_WIDTH*k +: DATA_WIDTH]
- y_valid  input  K  per-column valid; column k pushes y_in slice k when set
- out_row  output  DATA_WIDTH*K  aligned row; column k at bits [DATA_WIDTH*k +: DATA_WIDTH]
- out_valid  output  1  out_row is valid
- out_ready  input  1  consumer accepts the row
- out_idx  output  $clog2(M)  row index of out_row, 0..M-1
- out_last  output  1  out_row is row M-1
- busy  output  1  job in progress
- done  output  1  one-cycle pulse after the last row is accepted
- err  output  1  sticky protocol error

Behaviour:
- Reset (rst_n low, async): FSM=IDLE, all FIFOs empty, row counter 0, out_valid=0, done=0, busy=0, err=0, out_row=0.
- FSM states and transitions:
  - IDLE -> RUN on start.
  - RUN -> FIN on the accepted pop of row M-1.
  - FIN -> IDLE after one cycle.
  - busy=1 in RUN. done=1 only in FIN.
- start in IDLE also clears err and the row counter. start in RUN or FIN is ignored and sets err.
- Push: in RUN, y_valid[k] writes slice k into FIFO k in the same cycle. The element is visible at the head the next cycle.
  - Push when FIFO k is full and not popping that cycle: data is dropped and err is set.
  - Push outside RUN: data is dropped and err is set.
- out_valid is combinational: (state==RUN) and every FIFO is non-empty. out_row is the concatenation of the FIFO heads. Minimum latency from the last column's push to out_valid is 1 cycle.
- Pop: out_valid and out_ready pops all K FIFOs together and increments the row counter. Holds:
  - out_row, out_idx and out_last stay stable while out_valid=1 and out_ready=0.
  - Push and pop on the same FIFO in one cycle are legal, including when full; occupancy is unchanged.
- Row counter: out_idx = counter, out_last = (counter==M-1). It wraps to 0 on the accepted pop of row M-1.
- Pushes beyond M rows per column in a job are not rejected. They remain queued and set err when the FSM enters IDLE with any FIFO non-empty. Residual entries are flushed in FIN.
- Arithmetic: no widening or saturation; elements pass through bit-exact.
- Reset asserted mid-job: immediate return to the reset state; no done pulse.

Decomposition:
- Shared package collector_pkg holds:
  - state enum {IDLE, RUN, FIN}
  - localparam IDX_W = $clog2(M)
  - localparam PTR_W = $clog2(DEPTH)
- One sub-module: collector_col_fifo (DATA_WIDTH, DEPTH).
  - Single-clock FIFO with push, pop, flush, full, empty and head data; occupancy counter is PTR_W+1 bits.
  - Instantiated K times via generate.
- Top level holds the FSM, row counter, out_valid AND-reduce and error logic.

Test Plan (M=5, K=4, DATA_WIDTH=8, DEPTH=8):
- Skewed stream:
  - Stimulus: start; column k receives rows 0..4 with value 0x10*m+k starting at cycle k; out_ready=1.
  - Required response:
    - 5 rows, row m = {0x10m+3, 0x10m+2, 0x10m+1, 0x10m}.
    - out_idx 0..4, out_last only on row 4.
    - done one cycle after row 4; err=0.
- Backpressure:
  - Stimulus: same stream with out_ready=0 for cycles 0..9, then out_ready=1.
  - Required response: no data lost; row 0 held stable while stalled; all 5 rows correct; err=0.
- Overflow:
  - Stimulus: start, out_ready=0, push 9 entries into column 0.
  - Required response: err=1 on the 9th push; FIFO 0 holds the first 8 entries.
- Push outside a job:
  - Stimulus: y_valid=4'b0001 in IDLE.
  - Required response: err=1, out_valid stays 0.
  - Follow-up: a later start clears err.
- Reset mid-job:
  - Stimulus: deassert rst_n after row 2 is accepted.
  - Required response: outputs return to reset values immediately; no done pulse.
  - Follow-up: a new job runs clean.
- Simultaneous push and pop on a full column:
  - Stimulus: FIFO 3 full, out_valid=1, out_ready=1, y_valid[3]=1.
  - Required response: occupancy stays 8, err=0, order preserved.
